// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
// Holds the FSM state type and the per-frame sample count.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } uart_state_t;

    // Start bit is sample 0; data bits are samples 1..8; the stop bit is sample 9.
    localparam logic [3:0] UART_FRAME_BITS = 4'd9;

    localparam int BAUD_W = 14;

endpackage

// File: rtl/uart_rx_sync.sv
// RX metastability synchronizer plus falling-edge detector.
// Every flop resets high so that an idle line never looks like a start edge.
module rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            prev_q <= rx_s;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = prev_q & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with mid-bit sampling.
// Bit period is baud_goal+1 clocks.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX,
    input  logic [BAUD_W-1:0] baud_goal,
    input  logic              clr_rdy,
    output logic [7:0]        rx_data,
    output logic              rdy,
    output logic              frame_err
);

    logic rx_s;
    logic fall;

    rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .rx  (RX),
        .rx_s(rx_s),
        .fall(fall)
    );

    uart_state_t       state, state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_n;
    logic [3:0]        bit_cnt, bit_n;
    logic [8:0]        shift_reg, shift_n;
    logic [7:0]        data_n;
    logic              rdy_n;
    logic              err_n;
    logic              sample_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= 8'h00;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_cnt   <= bit_n;
            shift_reg <= shift_n;
            rx_data   <= data_n;
            rdy       <= rdy_n;
            frame_err <= err_n;
        end
    end

    // The start bit is sampled half a period in; all later bits one full period apart.
    assign sample_hit = (bit_cnt == 4'd0) ? (baud_cnt == (baud_goal >> 1))
                                          : (baud_cnt == baud_goal);

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        data_n  = rx_data;
        rdy_n   = rdy;
        err_n   = frame_err;

        if (clr_rdy) begin
            rdy_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (fall) begin
                    state_n = RECV;
                    baud_n  = '0;
                    bit_n   = '0;
                    rdy_n   = 1'b0;
                end
            end
            RECV: begin
                baud_n = baud_cnt + 14'd1;
                if (sample_hit) begin
                    baud_n = '0;
                    if (bit_cnt == 4'd0) begin
                        if (rx_s) begin
                            state_n = IDLE;
                        end else begin
                            bit_n = 4'd1;
                        end
                    end else if (bit_cnt < UART_FRAME_BITS) begin
                        shift_n = {rx_s, shift_reg[8:1]};
                        bit_n   = bit_cnt + 4'd1;
                    end else begin
                        // A low stop bit still delivers the byte, just flagged.
                        data_n  = shift_reg[8:1];
                        rdy_n   = 1'b1;
                        err_n   = ~rx_s;
                        state_n = IDLE;
                        bit_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural serial transmitter drives RX,
// and every delivered byte is compared against the frames the bench chose to send.
module tb_uart_rx;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic [13:0] baud_goal = 14'd433;
    logic        clr_rdy = 1'b0;
    logic [7:0]  rx_data;
    logic        rdy;
    logic        frame_err;

    int          checks = 0;
    int          failures = 0;
    int          n_exp = 0;
    longint      cyc = 0;
    logic        rdy_prev = 1'b0;

    logic [7:0]  got_data[$];
    logic        got_err[$];
    longint      got_cyc[$];

    uart_rx #(
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RX       (rx),
        .baud_goal(baud_goal),
        .clr_rdy  (clr_rdy),
        .rx_data  (rx_data),
        .rdy      (rdy),
        .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Record each rising edge of rdy together with the byte and error flag it carries.
    always @(negedge clk) begin
        if (rdy === 1'b1 && rdy_prev !== 1'b1) begin
            got_data.push_back(rx_data);
            got_err.push_back(frame_err);
            got_cyc.push_back(cyc);
        end
        rdy_prev = rdy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_window(input string tag, input longint observed, input longint lo, input longint hi);
        checks++;
        assert (observed >= lo && observed <= hi) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
        end
    endtask

    task automatic idle_line(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    // Serialise start, 8 data bits LSB first, then stop; clr_rdy is held high over
    // frame cycles [clr_from, clr_to]; n_bits < 10 cuts the frame short.
    task automatic apply_stimulus(input logic [7:0] data, input logic stop, input int clr_from,
                                  input int clr_to, input int n_bits, output longint start_cyc);
        logic [9:0] frame;
        int         period;
        int         k;
        frame     = {stop, data, 1'b0};
        period    = int'(baud_goal) + 1;
        k         = 0;
        start_cyc = cyc;
        for (int b = 0; b < n_bits; b++) begin
            rx = frame[b];
            for (int c = 0; c < period; c++) begin
                clr_rdy = (k >= clr_from && k <= clr_to);
                tick();
                k++;
            end
        end
        clr_rdy = 1'b0;
    endtask

    // The line edge reaches rx_s two clocks after it is driven; rdy must follow
    // 9 bit periods plus half a bit plus one clock later, with one clock of slack.
    task automatic check_frame(input string tag, input logic [7:0] data, input logic err,
                               input longint start_cyc, input int goal);
        int     idx;
        longint nominal;
        idx = n_exp;
        n_exp++;
        nominal = start_cyc + 2 + 9 * (goal + 1) + (goal >> 1) + 1;
        check_output({tag, "_count"}, got_data.size(), n_exp);
        if (got_data.size() > idx) begin
            check_output({tag, "_data"}, got_data[idx], data);
            check_output({tag, "_ferr"}, got_err[idx], err);
            check_window({tag, "_rdy_time"}, got_cyc[idx], nominal - 1, nominal + 1);
        end
    endtask

    initial begin
        longint     t0;
        logic [7:0] r_data;
        logic       r_stop;
        int         r_gap;
        logic [7:0] last_data;

        repeat (3) tick();
        check_output("reset_rdy", rdy, 1'b0);
        check_output("reset_data", rx_data, 8'h00);
        check_output("reset_ferr", frame_err, 1'b0);
        check_output("reset_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        idle_line(20);

        $display("[TB] single frame 0xA5");
        apply_stimulus(8'hA5, 1'b1, -1, -1, 10, t0);
        idle_line(10);
        check_frame("a5", 8'hA5, 1'b0, t0, 433);
        check_output("a5_rdy_held", rdy, 1'b1);
        clr_rdy = 1'b1;
        tick();
        clr_rdy = 1'b0;
        check_output("clr_rdy_clears", rdy, 1'b0);

        $display("[TB] back-to-back 0x00 then 0xFF");
        apply_stimulus(8'h00, 1'b1, -1, -1, 10, t0);
        check_frame("b2b_00", 8'h00, 1'b0, t0, 433);
        apply_stimulus(8'hFF, 1'b1, 0, 0, 10, t0);
        idle_line(10);
        check_frame("b2b_ff", 8'hFF, 1'b0, t0, 433);
        check_output("b2b_rdy", rdy, 1'b1);

        $display("[TB] 100-clock glitch");
        rx = 1'b0;
        repeat (100) tick();
        idle_line(434);
        check_output("glitch_no_byte", got_data.size(), n_exp);
        check_output("glitch_state", 32'(dut.state), 32'(IDLE));
        check_output("glitch_data", rx_data, 8'hFF);

        $display("[TB] 0x3C with low stop bit, then line held low");
        apply_stimulus(8'h3C, 1'b0, -1, -1, 10, t0);
        repeat (868) tick();
        check_frame("ferr", 8'h3C, 1'b1, t0, 433);
        check_output("ferr_rdy", rdy, 1'b1);
        check_output("held_low_state", 32'(dut.state), 32'(IDLE));
        idle_line(434);
        apply_stimulus(8'h5A, 1'b1, -1, -1, 10, t0);
        idle_line(10);
        check_frame("ferr_clear", 8'h5A, 1'b0, t0, 433);

        $display("[TB] reset at bit 4 of 0x55");
        apply_stimulus(8'h55, 1'b1, -1, -1, 5, t0);
        rx  = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("midrst_rdy", rdy, 1'b0);
        check_output("midrst_data", rx_data, 8'h00);
        check_output("midrst_state", 32'(dut.state), 32'(IDLE));
        idle_line(3000);
        check_output("midrst_no_byte", got_data.size(), n_exp);
        apply_stimulus(8'h81, 1'b1, -1, -1, 10, t0);
        idle_line(10);
        check_frame("after_rst", 8'h81, 1'b0, t0, 433);

        $display("[TB] clr_rdy coincident with rdy set");
        apply_stimulus(8'hC3, 1'b1, 9 * 434, 10 * 434 - 1, 10, t0);
        check_frame("set_wins", 8'hC3, 1'b0, t0, 433);
        check_output("set_wins_cleared_after", rdy, 1'b0);
        idle_line(10);

        $display("[TB] randomized frames at random bit rates");
        last_data = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            baud_goal = 14'($urandom_range(7, 80));
            r_data    = 8'($urandom_range(0, 255));
            r_stop    = ($urandom_range(0, 3) != 0);
            r_gap     = r_stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            apply_stimulus(r_data, r_stop, -1, -1, 10, t0);
            idle_line(r_gap * (int'(baud_goal) + 1) + 4);
            check_frame("rand", r_data, ~r_stop, t0, int'(baud_goal));
            check_output("rand_held_data", rx_data, r_data);
            last_data = r_data;
        end
        idle_line(20);
        check_output("final_data_held", rx_data, last_data);
        check_output("final_no_extra", got_data.size(), n_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of flops in the RX metastability synchronizer (legal range 2..3).
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on posedge clk.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset, sampled on posedge clk.
REQ-004 RX  input  1  SHALL be the asynchronous serial data input, idle high, 8N1 LSB-first framing.
REQ-005 baud_goal  input  14  SHALL set the bit period to baud_goal+1 clocks; it is the same value the transmitter uses, and is static while a frame is in progress.
REQ-006 clr_rdy  input  1  SHALL be a consumer pulse that clears rdy.
REQ-007 rx_data  output  8  SHALL hold the last received byte.
REQ-008 rdy  output  1  SHALL mark a new byte in rx_data and stay high until cleared.
REQ-009 frame_err  output  1  SHALL be high when the stop bit of the last completed frame sampled low.

Function
REQ-010 RX SHALL pass through a SYNC_STAGES-deep synchronizer whose flops reset to 1; all logic SHALL use only the synchronized value (rx_s).
REQ-011 The FSM SHALL have two states, IDLE and RECV.
REQ-012 In IDLE, a falling edge of rx_s (previous 1, current 0) SHALL cause a move to RECV, load the baud counter with 0, and set the bit counter to 0.
REQ-013 The baud counter SHALL be 14 bits wide and count up each clock in RECV.
REQ-014 The first sample (start bit) SHALL occur when the counter equals baud_goal>>1 (mid-bit); each later sample SHALL occur when the counter equals baud_goal.
REQ-015 The counter SHALL clear on every sample.
REQ-016 If the start-bit sample reads 1 (false start), the FSM SHALL return to IDLE with no change to rdy, rx_data or frame_err.
REQ-017 Samples 1..8 SHALL shift rx_s into a 9-bit shift register from the MSB end, so data bit 0 lands in rx_data[0].
REQ-018 Sample 9 is the stop bit. On it, the block SHALL in the same clock:
  - load rx_data from the shift register;
  - set rdy;
  - load frame_err with the inverted stop-bit sample;
  - return to IDLE.
  The byte SHALL be delivered even when the stop bit is 0.
REQ-019 The start edge is detected at the synchronizer output. rdy SHALL rise 9*(baud_goal+1) + (baud_goal>>1) + 1 clocks after that edge, ±1 clock.
REQ-020 rdy SHALL clear on clr_rdy, or on a start-edge detect in IDLE.
REQ-021 If a set of rdy (REQ-018) and clr_rdy occur in the same cycle, the set SHALL win.
REQ-022 rx_data and frame_err SHALL hold their values until the next completed frame.
REQ-023 Back-to-back frames SHALL be received with zero idle bits between them: a new start edge is detectable on the first IDLE cycle after the stop sample.
REQ-024 An RX low level in IDLE without a preceding high (e.g. a line held low) SHALL NOT start a frame.
REQ-025 The unused high counter bits SHALL still be compared, so baud_goal values up to 16383 are legal.

Reset
REQ-026 When rst is high, the block SHALL set:
  - state = IDLE;
  - rdy = 0, frame_err = 0, rx_data = 8'h00;
  - shift register = 0, both counters = 0;
  - synchronizer and edge-detect flops = 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output update; reception SHALL resume only on a fresh falling edge after rst deasserts.

Structure
REQ-028 The state enum (IDLE, RECV) and the bit-count constant 9 SHALL live in a shared uart_pkg package, also usable by the transmitter.
REQ-029 The synchronizer plus falling-edge detector SHALL be a sub-module named rx_sync.
REQ-030 All other logic SHALL be flat in uart_rx.

Verification
REQ-031 Bench SHALL use baud_goal=433 (50 MHz, 115200 baud), with RX driven by the existing UART transmitter module sending 8'hA5: rx_data=8'hA5, rdy=1, frame_err=0, with rdy timing per REQ-019.
REQ-032 Bench SHALL send 8'h00 then 8'hFF back-to-back with no idle gap, pulsing clr_rdy between them: both bytes received in order, rdy pulsed twice.
REQ-033 Bench SHALL drive a 100-clock low glitch on RX: no rdy, state returns to IDLE, rx_data unchanged.
REQ-034 Bench SHALL send 8'h3C with the stop bit forced low: rx_data=8'h3C, rdy=1, frame_err=1. A following good frame SHALL clear frame_err.
REQ-035 Bench SHALL assert rst for 1 clock mid-frame at bit 4 of 8'h55: rdy=0 and rx_data=8'h00 after reset, no spurious byte, then a correct reception of the next frame 8'h81.
REQ-036 Bench SHALL assert clr_rdy in the exact cycle rdy sets: rdy SHALL read 1 the next cycle.
